coreuart_tx_scheduler: RTL and testbench

//  Round-robin scheduler sharing one CoreUART transmitter among NUM_REQ byte

---
 rtl/coreuart_tx_scheduler_if.sv | 28 ++
 rtl/coreuart_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_coreuart_tx_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coreuart_tx_scheduler_if.sv
// Purpose : requester-side and UART host-side bus of the TX scheduler.
// Latency : none, wires only.
// Backpr. : REQ_READY (one-hot) accepts a requester byte; UART_TXRDY paces the UART writes.
// Ports   : REQ_VALID/REQ_DATA/REQ_LAST/REQ_READY per requester; UART_TXRDY/CSN/WEN/DATA to the UART.
interface coreuart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   REQ_VALID;
    logic [8*NUM_REQ-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]   REQ_LAST;
    logic [NUM_REQ-1:0]   REQ_READY;
    logic                 UART_TXRDY;
    logic                 UART_CSN;
    logic                 UART_WEN;
    logic [7:0]           UART_DATA;

    // master: requesters plus the UART, which drive the scheduler's inputs
    modport master (
        output REQ_VALID, REQ_DATA, REQ_LAST, UART_TXRDY,
        input  REQ_READY, UART_CSN, UART_WEN, UART_DATA
    );

    // slave: the scheduler itself
    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_LAST, UART_TXRDY,
        output REQ_READY, UART_CSN, UART_WEN, UART_DATA
    );
endinterface

// File: rtl/coreuart_tx_scheduler.sv
// Purpose : round-robin scheduler sharing one CoreUART transmitter among NUM_REQ byte requesters, with packet lock.
// Latency : accept in cycle N, UART write strobe in N+1; accept-to-accept spacing at least SETTLE_CYC+3.
// Backpr. : REQ_READY only in IDLE with UART_TXRDY=1; a held lock blocks other requesters until LAST or timeout.
// Ports   : CLK, RESET_N (async, active low); bus (slave modport); GRANT_ID, LOCKED, LOCK_DROP, BUSY status.
module coreuart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int SETTLE_CYC   = 2,
    parameter int LOCK_TIMEOUT = 255,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    coreuart_tx_scheduler_if.slave bus,
    output logic [IDW-1:0]       GRANT_ID,
    output logic                 LOCKED,
    output logic                 LOCK_DROP,
    output logic                 BUSY
);
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_SETTLE, ST_WAIT_RDY} state_t;

    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYC - 1);
    localparam logic [15:0] LOCK_LIM    = 16'(LOCK_TIMEOUT);

    state_t             state, state_nxt;
    logic [IDW-1:0]     ptr;
    logic [3:0]         settle_cnt;
    logic [15:0]        lock_cnt;
    logic [7:0]         uart_data_q;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] lock_mask;
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [7:0]         win_byte;
    logic               win_last;
    int                 pos;

    logic [NUM_REQ-1:0] ready_c;
    logic               csn_c;
    logic               wen_c;
    logic               accept;

    // Winner search from ptr+1 upward with wrap; iterating from the far end
    // down means the nearest set bit is the one left in win_idx.
    always_comb begin
        lock_mask = '0;
        pos       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = bus.REQ_VALID;
        if (LOCKED) begin
            lock_mask[GRANT_ID] = 1'b1;
            cand = bus.REQ_VALID & lock_mask;
        end
        for (int k = NUM_REQ; k >= 1; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            if (cand[IDW'(pos)]) begin
                win_found = 1'b1;
                win_idx   = IDW'(pos);
            end
        end
        win_byte = bus.REQ_DATA[8*int'(win_idx) +: 8];
        win_last = bus.REQ_LAST[win_idx];
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // READY is gated by RESET_N so nothing is accepted while reset is held.
    always_comb begin
        state_nxt = state;
        ready_c   = '0;
        csn_c     = 1'b1;
        wen_c     = 1'b1;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (RESET_N && bus.UART_TXRDY && win_found) begin
                    accept           = 1'b1;
                    ready_c[win_idx] = 1'b1;
                    state_nxt        = ST_WRITE;
                end
            end
            ST_WRITE: begin
                csn_c     = 1'b0;
                wen_c     = 1'b0;
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                // TXRDY is stale right after a write, so it is not looked at here
                if (settle_cnt == 4'd0) state_nxt = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (bus.UART_TXRDY) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            uart_data_q <= 8'h00;
            GRANT_ID    <= '0;
            ptr         <= IDW'(NUM_REQ - 1);
            LOCKED      <= 1'b0;
            LOCK_DROP   <= 1'b0;
            lock_cnt    <= 16'd0;
            settle_cnt  <= 4'd0;
        end else begin
            LOCK_DROP <= 1'b0;
            if (state == ST_WRITE)
                settle_cnt <= SETTLE_INIT;
            else if (state == ST_SETTLE && settle_cnt != 4'd0)
                settle_cnt <= settle_cnt - 4'd1;

            if (accept) begin
                uart_data_q <= win_byte;
                GRANT_ID    <= win_idx;
                ptr         <= win_idx;
                LOCKED      <= ~win_last;
                lock_cnt    <= 16'd0;
            end else if (state == ST_IDLE && LOCKED && !bus.REQ_VALID[GRANT_ID]) begin
                // the lock is released on the edge where the idle count reaches the limit
                if (lock_cnt != LOCK_LIM) begin
                    lock_cnt <= lock_cnt + 16'd1;
                    if (lock_cnt == LOCK_LIM - 16'd1) begin
                        LOCKED    <= 1'b0;
                        LOCK_DROP <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.REQ_READY = ready_c;
    assign bus.UART_CSN  = csn_c;
    assign bus.UART_WEN  = wen_c;
    assign bus.UART_DATA = uart_data_q;
    assign BUSY          = (state != ST_IDLE);
endmodule

// File: tb/tb_coreuart_tx_scheduler.sv
// Purpose : self-checking bench for coreuart_tx_scheduler, directed scenarios plus randomized traffic.
// Latency : a cycle-age model predicts the strobe one cycle after accept, then settle and TXRDY wait.
// Backpr. : bench randomizes UART_TXRDY and requester VALID; every wait is bounded.
module tb_coreuart_tx_scheduler;
    localparam int N  = 4;
    localparam int S  = 2;
    localparam int LT = 8;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    coreuart_tx_scheduler_if #(.NUM_REQ(N)) bus ();
    logic [1:0] grant_id;
    logic       locked, lock_drop, busy;

    coreuart_tx_scheduler #(.NUM_REQ(N), .SETTLE_CYC(S), .LOCK_TIMEOUT(LT)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .bus       (bus.slave),
        .GRANT_ID  (grant_id),
        .LOCKED    (locked),
        .LOCK_DROP (lock_drop),
        .BUSY      (busy)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_acc_cyc = 0;
    logic [7:0] log_dat[$];
    int         log_gid[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_free: scheduler can take a byte; m_age: cycles since the last accept
    bit         m_free   = 1'b1;
    int         m_age    = 0;
    int         m_ptr    = N - 1;
    int         m_grant  = 0;
    bit         m_locked = 1'b0;
    int         m_cnt    = 0;
    bit         m_drop   = 1'b0;
    logic [7:0] m_data   = 8'h00;

    function automatic int rr_pick(input logic [N-1:0] cand, input int ptr);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (ptr + k) % N;
            if (cand[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge CLK) begin
        logic [N-1:0] cand;
        logic [N-1:0] exp_rdy;
        int  w;
        bit  acc;
        bit  strobe;
        bit  next_drop;
        if (!RESET_N) begin
            m_free = 1'b1; m_age = 0; m_ptr = N - 1; m_grant = 0;
            m_locked = 1'b0; m_cnt = 0; m_drop = 1'b0; m_data = 8'h00;
        end
        cand = bus.REQ_VALID;
        if (m_locked) cand = bus.REQ_VALID & (N'(1) << m_grant);
        w = rr_pick(cand, m_ptr);
        exp_rdy = '0;
        acc = 1'b0;
        if (RESET_N && m_free && bus.UART_TXRDY && w >= 0) begin
            exp_rdy[w] = 1'b1;
            acc = 1'b1;
        end
        strobe = !m_free && (m_age == 1);
        chk("req_ready", 32'(bus.REQ_READY), 32'(exp_rdy));
        chk("uart_csn",  32'(bus.UART_CSN),  32'(!strobe));
        chk("uart_wen",  32'(bus.UART_WEN),  32'(!strobe));
        chk("uart_data", 32'(bus.UART_DATA), 32'(m_data));
        chk("grant_id",  32'(grant_id),      32'(m_grant));
        chk("locked",    32'(locked),        32'(m_locked));
        chk("lock_drop", 32'(lock_drop),     32'(m_drop));
        chk("busy",      32'(busy),          32'(!m_free));
        if (RESET_N && !bus.UART_CSN && !bus.UART_WEN) begin
            log_dat.push_back(bus.UART_DATA);
            log_gid.push_back(int'(grant_id));
        end
        if (RESET_N) begin
            next_drop = 1'b0;
            if (acc) begin
                m_free   = 1'b0;
                m_age    = 1;
                m_data   = bus.REQ_DATA[8*w +: 8];
                m_grant  = w;
                m_ptr    = w;
                m_locked = !bus.REQ_LAST[w];
                m_cnt    = 0;
            end else if (m_free) begin
                if (m_locked && !bus.REQ_VALID[m_grant]) begin
                    if (m_cnt < LT) m_cnt++;
                    if (m_cnt == LT) begin
                        m_locked  = 1'b0;
                        next_drop = 1'b1;
                    end
                end
            end else begin
                // strobe at age 1, settle for ages 2..S+1, then wait for TXRDY
                if (m_age >= S + 2 && bus.UART_TXRDY) m_free = 1'b1;
                else m_age++;
            end
            m_drop = next_drop;
        end
    end

    // ---------------- stimulus helpers (return at posedge+1) ----------------
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic clear_inputs();
        bus.REQ_VALID = '0;
        bus.REQ_DATA  = '0;
        bus.REQ_LAST  = '0;
    endtask

    task automatic do_reset();
        tick();
        RESET_N = 1'b0;
        clear_inputs();
        bus.UART_TXRDY = 1'b1;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] d, input bit l);
        bus.REQ_VALID[i]      = v;
        bus.REQ_DATA[8*i +: 8] = d;
        bus.REQ_LAST[i]       = l;
    endtask

    task automatic wait_accept(input int idx, input string nm);
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.REQ_READY[idx]) begin
                last_acc_cyc = cyc;
                tick();
                return;
            end
            tick();
        end
        chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_log(input int n, input string nm);
        for (int i = 0; i < 400; i++) begin
            if (log_dat.size() >= n) return;
            tick();
        end
        chk({nm, "_strobe_timeout"}, 32'(log_dat.size()), 32'(n));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            #1;
            if (!busy) begin
                tick();
                return;
            end
            tick();
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d_cyc, a_cyc, rdy_seen, got;
        int exp2[5];
        logic [7:0] exp3[4];
        exp2 = '{0, 1, 2, 3, 0};
        exp3 = '{8'h11, 8'h22, 8'h33, 8'h99};
        clear_inputs();
        bus.UART_TXRDY = 1'b0;
        do_reset();

        // 1: single byte from requester 0
        set_req(0, 1'b1, 8'hA5, 1'b1);
        bus.UART_TXRDY = 1'b1;
        #1;
        chk("t1_ready", 32'(bus.REQ_READY), 32'h1);
        chk("t1_csn_before", 32'(bus.UART_CSN), 32'd1);
        tick();
        bus.REQ_VALID = '0;
        #1;
        chk("t1_csn", 32'(bus.UART_CSN), 32'd0);
        chk("t1_wen", 32'(bus.UART_WEN), 32'd0);
        chk("t1_data", 32'(bus.UART_DATA), 32'hA5);
        chk("t1_locked", 32'(locked), 32'd0);
        tick();
        #1;
        chk("t1_csn_after", 32'(bus.UART_CSN), 32'd1);
        wait_idle();

        // 2: all requesters valid, grant order from reset
        do_reset();
        base = log_dat.size();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
        wait_log(base + 5, "t2");
        clear_inputs();
        for (int k = 0; k < 5; k++)
            if (log_gid.size() > base + k) chk($sformatf("t2_grant%0d", k), 32'(log_gid[base+k]), 32'(exp2[k]));
        wait_idle();

        // 3: locked 3-byte packet from requester 2 ahead of requester 0
        do_reset();
        base = log_dat.size();
        set_req(2, 1'b1, 8'h11, 1'b0);
        wait_accept(2, "t3a");
        set_req(0, 1'b1, 8'h99, 1'b1);
        set_req(2, 1'b1, 8'h22, 1'b0);
        wait_accept(2, "t3b");
        set_req(2, 1'b1, 8'h33, 1'b1);
        wait_accept(2, "t3c");
        set_req(2, 1'b0, 8'h00, 1'b0);
        wait_accept(0, "t3d");
        clear_inputs();
        wait_log(base + 4, "t3");
        for (int k = 0; k < 4; k++)
            if (log_dat.size() > base + k) chk($sformatf("t3_byte%0d", k), 32'(log_dat[base+k]), 32'(exp3[k]));
        wait_idle();

        // 4: lock timeout on requester 1, then requester 3 wins
        do_reset();
        base = log_dat.size();
        set_req(1, 1'b1, 8'h44, 1'b0);
        wait_accept(1, "t4a");
        a_cyc = last_acc_cyc;
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b1, 8'h77, 1'b1);
        set_req(0, 1'b1, 8'h55, 1'b1);
        d_cyc = -1;
        for (int i = 0; i < 60 && d_cyc < 0; i++) begin
            #1;
            if (lock_drop) d_cyc = cyc;
            else tick();
        end
        chk("t4_drop_delay", 32'(d_cyc - a_cyc), 32'd13);
        chk("t4_no_grant_in_lock", 32'(log_dat.size() - base), 32'd1);
        wait_log(base + 2, "t4");
        clear_inputs();
        if (log_gid.size() > base + 1) begin
            chk("t4_next_grant", 32'(log_gid[base+1]), 32'd3);
            chk("t4_next_data", 32'(log_dat[base+1]), 32'h77);
        end
        wait_idle();

        // 5: TXRDY toggling in settle, then held low for 100 cycles
        set_req(0, 1'b1, 8'h5A, 1'b1);
        bus.UART_TXRDY = 1'b1;
        wait_accept(0, "t5a");
        clear_inputs();
        set_req(1, 1'b1, 8'h3C, 1'b1);
        bus.UART_TXRDY = 1'b1; tick();
        bus.UART_TXRDY = 1'b0; tick();
        bus.UART_TXRDY = 1'b1; tick();
        bus.UART_TXRDY = 1'b0;
        base = log_dat.size();
        rdy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (|bus.REQ_READY) rdy_seen++;
            tick();
        end
        chk("t5_ready_while_low", 32'(rdy_seen), 32'd0);
        chk("t5_strobes_while_low", 32'(log_dat.size() - base), 32'd0);
        bus.UART_TXRDY = 1'b1;
        wait_accept(1, "t5b");
        clear_inputs();
        wait_log(base + 1, "t5");
        if (log_dat.size() > base) chk("t5_data", 32'(log_dat[base]), 32'h3C);
        wait_idle();

        // 6: reset during the write of requester 2
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'hC0 + i), 1'b1);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            #1;
            if (!bus.UART_CSN && grant_id == 2'd2) got = 1;
            else tick();
        end
        chk("t6_reached_write", 32'(got), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("t6_csn_reset", 32'(bus.UART_CSN), 32'd1);
        chk("t6_wen_reset", 32'(bus.UART_WEN), 32'd1);
        chk("t6_busy_reset", 32'(busy), 32'd0);
        tick();
        tick();
        RESET_N = 1'b1;
        base = log_dat.size();
        wait_log(base + 1, "t6");
        clear_inputs();
        if (log_gid.size() > base) chk("t6_first_grant", 32'(log_gid[base]), 32'd0);
        wait_idle();

        // randomized traffic with varying request density
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < N; i++)
                    set_req(i, ($urandom_range(0, 7) < 2 * ph + 1), 8'($urandom), 1'($urandom_range(0, 1)));
                bus.UART_TXRDY = ($urandom_range(0, 9) != 0);
                tick();
            end
        end
        clear_inputs();
        bus.UART_TXRDY = 1'b1;
        wait_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
